// File: rtl/lfsr_crc_check_pkg.sv
// rtl/lfsr_crc_check_pkg.sv - shared constants, FCS depth helper and frame states
// Purpose: definitions shared by the CRC checker and its LFSR core.
// Ports: none (package).
package lfsr_crc_check_pkg;

  // Ethernet CRC32 defaults
  localparam logic [31:0] ETH_CRC32_POLY = 32'h04c11db7;
  localparam logic [31:0] ETH_CRC32_INIT = 32'hffffffff;

  // Frame progress: IDLE has no beats buffered, FILL is still loading the
  // delay line, RUN has a full delay line and pops one beat per push.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } frame_state_t;

  // Number of beats occupied by the FCS.
  function automatic int fcs_depth(input int lfsr_width, input int data_width);
    return lfsr_width / data_width;
  endfunction

endpackage

// File: rtl/lfsr_crc_check_lfsr.sv
// rtl/lfsr_crc_check_lfsr.sv - combinational CRC/LFSR advance by one data beat
// Purpose: next LFSR state after shifting DATA_WIDTH data bits into lfsr_in.
// Ports:
//   data_in  [DATA_WIDTH-1:0] beat shifted into the register
//   lfsr_in  [LFSR_WIDTH-1:0] current state
//   lfsr_out [LFSR_WIDTH-1:0] state after the beat
module lfsr #(
  parameter int                    LFSR_WIDTH  = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 32'h04c11db7,
  parameter string                 LFSR_CONFIG = "GALOIS",
  parameter int                    REVERSE     = 1,
  parameter int                    DATA_WIDTH  = 8,
  parameter string                 STYLE       = "AUTO"
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] lfsr_in,
  output logic [LFSR_WIDTH-1:0] lfsr_out
);

  // Reflected mode works on a bit-reversed register, so the taps reverse too.
  localparam logic [LFSR_WIDTH-1:0] POLY_REV = {<<{LFSR_POLY}};
  localparam bit FIB = (LFSR_CONFIG == "FIBONACCI");

  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(
    input logic [LFSR_WIDTH-1:0] s,
    input logic [DATA_WIDTH-1:0] d
  );
    logic [LFSR_WIDTH-1:0] st;
    logic                  fb;
    st = s;
    fb = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (REVERSE != 0) begin
        // LSB of each beat first
        if (FIB) begin
          fb = d[i] ^ (^(st & POLY_REV));
          st = {fb, st[LFSR_WIDTH-1:1]};
        end else begin
          fb = st[0] ^ d[i];
          st = st >> 1;
          if (fb) st = st ^ POLY_REV;
        end
      end else begin
        // MSB of each beat first
        if (FIB) begin
          fb = d[DATA_WIDTH-1-i] ^ (^(st & LFSR_POLY));
          st = {st[LFSR_WIDTH-2:0], fb};
        end else begin
          fb = st[LFSR_WIDTH-1] ^ d[DATA_WIDTH-1-i];
          st = st << 1;
          if (fb) st = st ^ LFSR_POLY;
        end
      end
    end
    return st;
  endfunction

  generate
    if (STYLE == "REDUCTION") begin : g_reduction
      // The map is linear: XOR together the response to each set input bit.
      always_comb begin
        logic [LFSR_WIDTH-1:0] w_unit_s;
        logic [DATA_WIDTH-1:0] w_unit_d;
        lfsr_out = '0;
        for (int j = 0; j < LFSR_WIDTH; j++) begin
          w_unit_s    = '0;
          w_unit_s[j] = 1'b1;
          if (lfsr_in[j]) lfsr_out = lfsr_out ^ lfsr_step(w_unit_s, '0);
        end
        for (int k = 0; k < DATA_WIDTH; k++) begin
          w_unit_d    = '0;
          w_unit_d[k] = 1'b1;
          if (data_in[k]) lfsr_out = lfsr_out ^ lfsr_step('0, w_unit_d);
        end
      end
    end else begin : g_loop
      assign lfsr_out = lfsr_step(lfsr_in, data_in);
    end
  endgenerate

endmodule

// File: rtl/lfsr_crc_check.sv
// rtl/lfsr_crc_check.sv - receive-side CRC check with FCS stripping
// Purpose: delays the stream by the FCS length, folds payload beats into a CRC,
//   compares it with the trailing FCS and flags each frame good, bad or runt.
// Optional: define LFSR_CRC_CHECK_STATS_EN for saturating per-outcome counters.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   s_data/s_valid/s_last       input beats, s_last on the final FCS beat
//   m_data/m_valid/m_last       payload beats with the FCS removed
//   m_crc_err                   FCS mismatch, qualified by m_valid & m_last
//   frame_good/bad/runt         one-cycle outcome pulses
//   stat_good/bad/runt [15:0]   outcome counters (LFSR_CRC_CHECK_STATS_EN only)
module lfsr_crc_check
  import lfsr_crc_check_pkg::*;
#(
  parameter int                    LFSR_WIDTH  = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = ETH_CRC32_POLY,
  parameter logic [LFSR_WIDTH-1:0] LFSR_INIT   = {LFSR_WIDTH{1'b1}},
  parameter string                 LFSR_CONFIG = "GALOIS",
  parameter int                    REVERSE     = 1,
  parameter int                    INVERT      = 1,
  parameter int                    DATA_WIDTH  = 8,
  parameter string                 STYLE       = "AUTO"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  output logic                  m_crc_err,
  output logic                  frame_good,
  output logic                  frame_bad,
`ifdef LFSR_CRC_CHECK_STATS_EN
  output logic [15:0]           stat_good,
  output logic [15:0]           stat_bad,
  output logic [15:0]           stat_runt,
`endif
  output logic                  frame_runt
);

  localparam int D  = fcs_depth(LFSR_WIDTH, DATA_WIDTH);
  localparam int CW = $clog2(D + 1);

  frame_state_t          r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_dly [D];
  logic [LFSR_WIDTH-1:0] r_crc;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_m_valid, r_m_last, r_m_err, r_good, r_bad, r_runt;

  logic                  w_pop, w_runt, w_mismatch;
  logic [LFSR_WIDTH-1:0] w_lfsr_out, w_fcs, w_crc_cmp;
  logic [DATA_WIDTH-1:0] w_fcs_beat [D];

  lfsr #(
    .LFSR_WIDTH (LFSR_WIDTH),
    .LFSR_POLY  (LFSR_POLY),
    .LFSR_CONFIG(LFSR_CONFIG),
    .REVERSE    (REVERSE),
    .DATA_WIDTH (DATA_WIDTH),
    .STYLE      (STYLE)
  ) u_lfsr (
    .data_in (r_dly[0]),
    .lfsr_in (r_crc),
    .lfsr_out(w_lfsr_out)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    w_runt      = 1'b0;
    if (s_valid) begin
      if (r_state == ST_RUN) begin
        w_pop = 1'b1;
        if (s_last) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end else if (s_last) begin
        // Frame ended before the delay line filled: no payload at all.
        w_runt      = 1'b1;
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt   = r_cnt + CW'(1);
        w_state_nxt = (w_cnt_nxt == CW'(D)) ? ST_RUN : ST_FILL;
      end
    end
  end

  // On the s_last beat the FCS is delay entries 1..D-1 followed by s_data.
  always_comb begin
    for (int k = 0; k < D - 1; k++) w_fcs_beat[k] = r_dly[k+1];
    w_fcs_beat[D-1] = s_data;
    w_fcs = '0;
    for (int k = 0; k < D; k++) begin
      if (REVERSE != 0) w_fcs[k*DATA_WIDTH +: DATA_WIDTH] = w_fcs_beat[k];
      else              w_fcs[(D-1-k)*DATA_WIDTH +: DATA_WIDTH] = w_fcs_beat[k];
    end
  end

  assign w_crc_cmp  = (INVERT != 0) ? ~w_lfsr_out : w_lfsr_out;
  assign w_mismatch = (w_fcs != w_crc_cmp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_dly     <= '{default: '0};
      r_crc     <= LFSR_INIT;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_err   <= 1'b0;
      r_good    <= 1'b0;
      r_bad     <= 1'b0;
      r_runt    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_m_valid <= w_pop;
      r_m_last  <= w_pop & s_last;
      r_m_err   <= w_pop & s_last & w_mismatch;
      r_good    <= w_pop & s_last & ~w_mismatch;
      r_bad     <= w_pop & s_last & w_mismatch;
      r_runt    <= w_runt;
      if (w_pop) r_m_data <= r_dly[0];
      if (s_valid) begin
        for (int i = 0; i < D - 1; i++) r_dly[i] <= r_dly[i+1];
        r_dly[D-1] <= s_data;
      end
      // Reinitialise on the last beat so the next frame can follow directly.
      if (s_valid && s_last) r_crc <= LFSR_INIT;
      else if (w_pop)        r_crc <= w_lfsr_out;
    end
  end

  assign m_data     = r_m_data;
  assign m_valid    = r_m_valid;
  assign m_last     = r_m_last;
  assign m_crc_err  = r_m_err;
  assign frame_good = r_good;
  assign frame_bad  = r_bad;
  assign frame_runt = r_runt;

`ifdef LFSR_CRC_CHECK_STATS_EN
  logic [15:0] r_stat_good, r_stat_bad, r_stat_runt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_good <= '0;
      r_stat_bad  <= '0;
      r_stat_runt <= '0;
    end else begin
      if (r_good && r_stat_good != 16'hffff) r_stat_good <= r_stat_good + 16'd1;
      if (r_bad  && r_stat_bad  != 16'hffff) r_stat_bad  <= r_stat_bad  + 16'd1;
      if (r_runt && r_stat_runt != 16'hffff) r_stat_runt <= r_stat_runt + 16'd1;
    end
  end

  assign stat_good = r_stat_good;
  assign stat_bad  = r_stat_bad;
  assign stat_runt = r_stat_runt;
`endif

endmodule

// File: tb/tb_lfsr_crc_check.sv
// tb/tb_lfsr_crc_check.sv - directed self-checking bench for lfsr_crc_check
module tb_lfsr_crc_check;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic [7:0] m_data;
  logic       m_valid, m_last, m_crc_err, frame_good, frame_bad, frame_runt;
`ifdef LFSR_CRC_CHECK_STATS_EN
  logic [15:0] stat_good, stat_bad, stat_runt;
`endif

  lfsr_crc_check dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_crc_err (m_crc_err),
    .frame_good(frame_good),
    .frame_bad (frame_bad),
`ifdef LFSR_CRC_CHECK_STATS_EN
    .stat_good (stat_good),
    .stat_bad  (stat_bad),
    .stat_runt (stat_runt),
`endif
    .frame_runt(frame_runt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: cumulative record, sampled on the falling edge.
  int         cyc = 0;
  logic [7:0] q_data[$];
  bit         q_last[$];
  bit         q_err[$];
  int         n_good = 0, n_bad = 0, n_runt = 0, n_stray = 0;
  int         last_out_cyc = -1;
  int         last_in_cyc = -2;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_valid) begin
      q_data.push_back(m_data);
      q_last.push_back(m_last);
      q_err.push_back(m_crc_err);
      if (m_last) last_out_cyc = cyc;
    end else if (m_last || m_crc_err) begin
      n_stray++;
    end
    if (m_crc_err && !m_last) n_stray++;
    if (frame_good) n_good++;
    if (frame_bad)  n_bad++;
    if (frame_runt) n_runt++;
  end

  // Expected payload beats and snapshot of the monitor at test start.
  logic [7:0] e_data[$];
  bit         e_last[$];
  bit         e_err[$];
  int         b0, g0, x0, r0;

  task automatic mark();
    b0 = q_data.size();
    g0 = n_good;
    x0 = n_bad;
    r0 = n_runt;
    e_data.delete();
    e_last.delete();
    e_err.delete();
  endtask

  task automatic add_exp(input logic [7:0] f[$], input bit err);
    int np;
    np = f.size() - 4;
    for (int i = 0; i < np; i++) begin
      e_data.push_back(f[i]);
      e_last.push_back(i == np - 1);
      e_err.push_back(err && (i == np - 1));
    end
  endtask

  task automatic verify(input string tag, input int eg, input int eb, input int er);
    check({tag, "_nbeats"}, q_data.size() - b0, e_data.size());
    for (int i = 0; i < e_data.size() && b0 + i < q_data.size(); i++)
      check($sformatf("%s_beat%0d", tag, i),
            {q_last[b0+i], q_err[b0+i], q_data[b0+i]},
            {e_last[i], e_err[i], e_data[i]});
    check({tag, "_good"}, n_good - g0, eg);
    check({tag, "_bad"},  n_bad - x0,  eb);
    check({tag, "_runt"}, n_runt - r0, er);
  endtask

  task automatic beat(input logic [7:0] d, input bit l);
    s_data  = d;
    s_valid = 1'b1;
    s_last  = l;
    @(posedge clk);
    if (l) last_in_cyc = cyc + 1;
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit gaps);
    for (int i = 0; i < f.size(); i++) begin
      if (gaps && i > 0) idle($urandom_range(0, 2));
      beat(f[i], i == f.size() - 1);
    end
  endtask

  logic [7:0] f_good[$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                            8'h26, 8'h39, 8'hF4, 8'hCB};
  logic [7:0] f_bad[$]  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h36, 8'h36, 8'h37, 8'h38, 8'h39,
                            8'h26, 8'h39, 8'hF4, 8'hCB};
  logic [7:0] f_runt[$] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic [7:0] f_one[$]  = '{8'h5A};
  // Shortest non-runt frame: one 00 payload byte, CRC32 = D202EF8D.
  logic [7:0] f_min[$]  = '{8'h00, 8'h8D, 8'hEF, 8'h02, 8'hD2};

  initial begin
    // Reset state
    #12;
    check("reset_outs", {m_valid, m_last, m_crc_err, frame_good, frame_bad, frame_runt, m_data}, 0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Good frame, including output latency of the final payload beat
    mark();
    add_exp(f_good, 1'b0);
    send_frame(f_good, 1'b0);
    idle(3);
    verify("good", 1, 0, 0);
    check("good_last_latency", last_out_cyc, last_in_cyc);

    // Bad FCS
    mark();
    add_exp(f_bad, 1'b1);
    send_frame(f_bad, 1'b0);
    idle(3);
    verify("bad", 0, 1, 0);

    // Runt of exactly D beats, and a single-beat frame
    mark();
    send_frame(f_runt, 1'b0);
    idle(3);
    verify("runt4", 0, 0, 1);
    mark();
    send_frame(f_one, 1'b0);
    idle(3);
    verify("runt1", 0, 0, 1);

    // D+1 beats: one payload byte
    mark();
    add_exp(f_min, 1'b0);
    send_frame(f_min, 1'b0);
    idle(3);
    verify("min", 1, 0, 0);

    // Back-to-back frames with gaps inside both
    mark();
    add_exp(f_good, 1'b0);
    add_exp(f_bad, 1'b1);
    send_frame(f_good, 1'b1);
    send_frame(f_bad, 1'b1);
    idle(3);
    verify("b2b", 1, 1, 0);

    // Runt immediately followed by a good frame
    mark();
    add_exp(f_good, 1'b0);
    send_frame(f_runt, 1'b0);
    send_frame(f_good, 1'b0);
    idle(3);
    verify("runt_then_good", 1, 0, 1);

    // Asynchronous reset in the middle of a frame
    mark();
    for (int i = 0; i < 6; i++) beat(f_good[i], 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_outs", {m_valid, m_last, m_crc_err, frame_good, frame_bad, frame_runt, m_data}, 0);
    @(negedge clk);
    #1;
    check("midrst_outs2", {m_valid, m_last, m_crc_err, frame_good, frame_bad, frame_runt, m_data}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    b0 = q_data.size();
    add_exp(f_good, 1'b0);
    send_frame(f_good, 1'b0);
    idle(3);
    verify("midrst", 1, 0, 0);

`ifdef LFSR_CRC_CHECK_STATS_EN
    rst_n = 1'b0;
    #3;
    check("stats_reset", {stat_good, stat_bad}, 0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 3; i++) send_frame(f_good, 1'b0);
    for (int i = 0; i < 2; i++) send_frame(f_bad, 1'b0);
    send_frame(f_runt, 1'b0);
    idle(3);
    check("stat_good", stat_good, 3);
    check("stat_bad", stat_bad, 2);
    check("stat_runt", stat_runt, 1);
    force dut.r_stat_good = 16'hfffe;
    #1;
    release dut.r_stat_good;
    idle(1);
    for (int i = 0; i < 3; i++) send_frame(f_good, 1'b0);
    idle(3);
    check("stat_good_sat", stat_good, 16'hffff);
`endif

    check("stray_flags", n_stray, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
